// File: rtl/pattern_bit_serializer.sv
// Parallel-to-serial front end for the pattern detector: a small word FIFO
// feeding a shift register that emits one bit per clock with no gaps between words.
module pattern_bit_serializer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       s_ready,
    output logic                       out_valid,
    output logic                       out_bit,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DATA_W);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [0:0]        state;
    logic [DATA_W-1:0] sh;
    logic [BW-1:0]     bc;

    logic push;
    logic pop;
    logic last_bit;

    // Ready looks only at the registered count, so a full FIFO refuses a
    // word even when the serializer is popping in the same cycle.
    assign s_ready  = (count != (AW+1)'(DEPTH));
    assign push     = s_valid && s_ready;
    assign last_bit = (state == SHIFT) && (bc == '0);
    assign pop      = (count != '0) && ((state == IDLE) || last_bit);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Reloading on the last bit keeps the stream gapless; the register is
    // cleared on the way back to IDLE so out_bit rests at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sh    <= '0;
            bc    <= '0;
        end else if (pop) begin
            state <= SHIFT;
            sh    <= mem[rd_ptr];
            bc    <= BW'(DATA_W - 1);
        end else if (state == SHIFT) begin
            if (bc == '0) begin
                state <= IDLE;
                sh    <= '0;
            end else begin
                sh <= (MSB_FIRST != 0) ? {sh[DATA_W-2:0], 1'b0}
                                       : {1'b0, sh[DATA_W-1:1]};
                bc <= bc - 1'b1;
            end
        end
    end

    assign out_valid  = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign out_bit    = (MSB_FIRST != 0) ? sh[DATA_W-1] : sh[0];
    assign fifo_count = count;

endmodule

// File: tb/tb_pattern_bit_serializer.sv
// Bench for pattern_bit_serializer: an MSB-first and an LSB-first instance share
// one input stream and are checked every cycle against a word-level queue model.
module tb_pattern_bit_serializer;

    localparam int DW  = 8;
    localparam int DEP = 4;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;

    logic       ready0, valid0, bit0, busy0;
    logic [2:0] count0;
    logic       ready1, valid1, bit1, busy1;
    logic [2:0] count1;

    int total = 0;
    int bad   = 0;

    // Reference model state: buffered words, word being sent, bits left in it.
    logic [DW-1:0] fifoQ [$];
    logic [DW-1:0] curWord;
    int            curBits;
    bit            lastPush;

    pattern_bit_serializer #(.DATA_W(DW), .DEPTH(DEP), .MSB_FIRST(1)) dutMsb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_ready(ready0), .out_valid(valid0), .out_bit(bit0),
        .busy(busy0), .fifo_count(count0)
    );

    pattern_bit_serializer #(.DATA_W(DW), .DEPTH(DEP), .MSB_FIRST(0)) dutLsb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_ready(ready1), .out_valid(valid1), .out_bit(bit1),
        .busy(busy1), .fifo_count(count1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        fifoQ.delete();
        curWord  = '0;
        curBits  = 0;
        lastPush = 1'b0;
    endtask

    // A word finishing (or an idle serializer) takes the oldest buffered word;
    // a word accepted this edge is only appended afterwards.
    task automatic modelStep();
        bit doPush;
        bit doPop;
        doPush = s_valid && (fifoQ.size() != DEP);
        doPop  = (curBits <= 1) && (fifoQ.size() > 0);
        if (doPop) begin
            curWord = fifoQ.pop_front();
            curBits = DW;
        end else if (curBits > 0) begin
            curBits--;
        end
        if (doPush) fifoQ.push_back(s_data);
        lastPush = doPush;
    endtask

    task automatic checkAll();
        logic expMsb;
        logic expLsb;
        checkOutput("valid_msb", {31'd0, valid0}, {31'd0, curBits > 0});
        checkOutput("valid_lsb", {31'd0, valid1}, {31'd0, curBits > 0});
        checkOutput("busy", {31'd0, busy0}, {31'd0, curBits > 0});
        checkOutput("count", {29'd0, count0}, fifoQ.size());
        checkOutput("count_lsb", {29'd0, count1}, fifoQ.size());
        checkOutput("ready", {31'd0, ready0}, {31'd0, fifoQ.size() != DEP});
        if (curBits > 0) begin
            expMsb = curWord[curBits-1];
            expLsb = curWord[DW-curBits];
            checkOutput("bit_msb", {31'd0, bit0}, {31'd0, expMsb});
            checkOutput("bit_lsb", {31'd0, bit1}, {31'd0, expLsb});
        end
    endtask

    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic pushWord(input logic [DW-1:0] w);
        int guard;
        s_valid = 1'b1;
        s_data  = w;
        guard   = 0;
        do begin
            applyStimulus();
            guard++;
        end while (!lastPush && guard < 50);
        if (!lastPush) checkOutput("push_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((curBits > 0 || fifoQ.size() > 0) && guard < 200) begin
            applyStimulus();
            guard++;
        end
        checkOutput("drain_timeout", {31'd0, guard < 200}, 32'd1);
        applyStimulus();
    endtask

    initial begin
        logic [DW-1:0] capMsb;
        logic [DW-1:0] capLsb;
        int            nValid;
        int            firstV;
        int            lastV;
        bit            sawFull;

        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        modelReset();

        #3;
        checkOutput("rst_valid", {31'd0, valid0}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy0}, 32'd0);
        checkOutput("rst_bit", {31'd0, bit0}, 32'd0);
        checkOutput("rst_count", {29'd0, count0}, 32'd0);
        #9;
        rst = 1'b1;
        #1;
        checkOutput("rst_ready", {31'd0, ready0}, 32'd1);

        // Single word A5: eight valid cycles, MSB-first bits spell A5.
        pushWord(8'hA5);
        capMsb = '0;
        nValid = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (valid0) begin
                capMsb = {capMsb[DW-2:0], bit0};
                nValid++;
            end
        end
        checkOutput("a5_bits", {24'd0, capMsb}, 32'hA5);
        checkOutput("a5_len", nValid, 32'd8);

        // Back-to-back FF then 00: one contiguous run of 16 valid cycles.
        pushWord(8'hFF);
        pushWord(8'h00);
        nValid = (valid0) ? 1 : 0;
        firstV = (valid0) ? 0 : -1;
        lastV  = firstV;
        for (int i = 1; i < 25; i++) begin
            applyStimulus();
            if (valid0) begin
                nValid++;
                if (firstV < 0) firstV = i;
                lastV = i;
            end
        end
        checkOutput("b2b_len", nValid, 32'd16);
        checkOutput("b2b_span", lastV - firstV + 1, 32'd16);

        // Hold valid with 1..6 so the FIFO fills and back-pressures.
        sawFull = 1'b0;
        for (int w = 1; w <= 6; w++) begin
            pushWord(DW'(w));
            if (count0 == 3'd4 && !ready0) sawFull = 1'b1;
            s_valid = 1'b1;
        end
        s_valid = 1'b0;
        checkOutput("full_seen", {31'd0, sawFull}, 32'd1);
        drain();

        // LSB-first single word 01.
        pushWord(8'h01);
        capLsb = '0;
        nValid = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (valid1 && nValid < DW) begin
                capLsb[nValid] = bit1;
                nValid++;
            end
        end
        checkOutput("lsb_bits", {24'd0, capLsb}, 32'h01);

        // Reset during the third bit of AA with 55 and 0F still buffered.
        pushWord(8'hAA);
        pushWord(8'h55);
        pushWord(8'h0F);
        applyStimulus();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'd0, valid0}, 32'd0);
        checkOutput("mid_rst_count", {29'd0, count0}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy1}, 32'd0);
        modelReset();
        #2;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) applyStimulus();

        // Random soak with random gaps and garbage data on idle cycles.
        for (int n = 0; n < 200; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                s_data = DW'($urandom);
                applyStimulus();
            end
            pushWord(DW'($urandom));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
